branch_sequencer: RTL and testbench

- Program-flow controller for the 9-bit-address core. Owns the PC, the 3-bit flag status register and the start/done handshake.
- Each run cycle it resolves one instruction's branch decision: branch target is immediate << 3, flags come from the flag register.
- Sits between the instruction memory address port and the decode/ALU stage. Sequences all branch resolution for the core.

---
 rtl/core_pkg.sv | 8 +
 rtl/branch_resolve.sv | 29 ++
 rtl/branch_sequencer.sv | 108 ++++++++++
 tb/tb_branch_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types and constants for the core's program-flow logic.
package core_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} seq_state_t;
  typedef enum logic [1:0] {BR_ALWAYS = 2'd0, BR_EQ = 2'd1, BR_LT = 2'd2, BR_NE = 2'd3} branch_cond_t;
  localparam int FLAG_EQ = 0;
  localparam int FLAG_LT = 1;
  localparam int FLAG_C  = 2;
endpackage

// File: rtl/branch_resolve.sv
// Pure combinational branch condition check and target generation.
module branch_resolve
  import core_pkg::*;
#(
  parameter int PC_W = 9
) (
  input  logic [1:0]      branch_cond_i,
  input  logic [2:0]      flags_i,
  input  logic [5:0]      immediate_i,
  output logic            cond_met_o,
  output logic [PC_W-1:0] target_o
);
  // carry is carried in the flag word but no condition code tests it
  logic unused_carry;
  assign unused_carry = flags_i[FLAG_C];

  always_comb begin
    cond_met_o = 1'b1;
    case (branch_cond_t'(branch_cond_i))
      BR_ALWAYS: cond_met_o = 1'b1;
      BR_EQ:     cond_met_o = flags_i[FLAG_EQ];
      BR_LT:     cond_met_o = flags_i[FLAG_LT];
      BR_NE:     cond_met_o = ~flags_i[FLAG_EQ];
      default:   cond_met_o = 1'b1;
    endcase
  end

  assign target_o = PC_W'({immediate_i, 3'b000});
endmodule

// File: rtl/branch_sequencer.sv
// Program-flow controller: PC, flag register, retired count and start/done handshake.
module branch_sequencer
  import core_pkg::*;
#(
  parameter int PC_W  = 9,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stall,
  input  logic             halt,
  input  logic             branch_instr,
  input  logic [1:0]       branch_cond,
  input  logic [5:0]       immediate,
  input  logic             change_flag,
  input  logic [2:0]       flag_in,
  output logic [PC_W-1:0]  pc,
  output logic [2:0]       flags,
  output logic             branch_taken,
  output logic             running,
  output logic             done,
  output logic             overflow,
  output logic [CNT_W-1:0] instr_count
);
  seq_state_t       state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [2:0]       flags_q, flags_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_q, armed_q;
  logic             start_rise, retire, cond_met;
  logic [PC_W-1:0]  target;

  branch_resolve #(.PC_W(PC_W)) u_resolve (
    .branch_cond_i(branch_cond),
    .flags_i      (flags_q),
    .immediate_i  (immediate),
    .cond_met_o   (cond_met),
    .target_o     (target)
  );

  // armed_q blocks a start held high through reset from looking like a fresh edge
  assign start_rise   = start & ~start_q & armed_q;
  assign retire       = (state_q == RUN) & ~stall & ~start_rise;
  assign branch_taken = retire & branch_instr & ~halt & cond_met;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flags_d = flags_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    if (start_rise) begin
      state_d = RUN;
      pc_d    = '0;
      flags_d = '0;
      ovf_d   = 1'b0;
      cnt_d   = '0;
    end else if (retire) begin
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
      if (change_flag) flags_d = flag_in;
      if (halt) begin
        state_d = DONE;
      end else if (branch_taken) begin
        pc_d = target;
      end else if (pc_q == '1) begin
        state_d = DONE;
        ovf_d   = 1'b1;
      end else begin
        pc_d = pc_q + PC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      flags_q <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else if (!stall || start_rise) begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flags_q <= flags_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      start_q <= start;
      armed_q <= armed_q | ~start;
    end
  end

  assign pc          = pc_q;
  assign flags       = flags_q;
  assign running     = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign overflow    = ovf_q;
  assign instr_count = cnt_q;
endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer: behavioural model compared every cycle plus literal anchors.
module tb_branch_sequencer;
  logic        clk = 1'b0;
  logic        rst_n, start, stall, halt, branch_instr, change_flag;
  logic [1:0]  branch_cond;
  logic [5:0]  immediate;
  logic [2:0]  flag_in;
  logic [8:0]  pc;
  logic [2:0]  flags;
  logic        branch_taken, running, done, overflow;
  logic [15:0] instr_count;

  int checks = 0;
  int errors = 0;

  branch_sequencer #(.PC_W(9), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .halt(halt),
    .branch_instr(branch_instr), .branch_cond(branch_cond), .immediate(immediate),
    .change_flag(change_flag), .flag_in(flag_in), .pc(pc), .flags(flags),
    .branch_taken(branch_taken), .running(running), .done(done),
    .overflow(overflow), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: state 0=idle 1=run 2=done. Previous start reads as 1 after reset,
  // so a launch needs start to be seen low first.
  int m_state, m_pc, m_flags, m_cnt, m_ovf;
  bit m_prev_start;

  function automatic bit m_rise();
    return start && !m_prev_start;
  endfunction

  function automatic bit m_cond();
    case (branch_cond)
      2'd0:    return 1'b1;
      2'd1:    return m_flags[0];
      2'd2:    return m_flags[1];
      default: return !m_flags[0];
    endcase
  endfunction

  function automatic bit m_taken();
    return m_state == 1 && !stall && !m_rise() && branch_instr && !halt && m_cond();
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state <= 0; m_pc <= 0; m_flags <= 0; m_cnt <= 0; m_ovf <= 0;
      m_prev_start <= 1'b1;
    end else begin
      m_prev_start <= start;
      if (m_rise()) begin
        m_state <= 1; m_pc <= 0; m_flags <= 0; m_cnt <= 0; m_ovf <= 0;
      end else if (m_state == 1 && !stall) begin
        m_cnt <= (m_cnt == 65535) ? m_cnt : m_cnt + 1;
        if (change_flag) m_flags <= flag_in;
        if (halt) m_state <= 2;
        else if (m_taken()) m_pc <= immediate * 8;
        else if (m_pc == 511) begin m_state <= 2; m_ovf <= 1; end
        else m_pc <= m_pc + 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("pc", pc, m_pc);
    chk("flags", flags, m_flags);
    chk("branch_taken", branch_taken, m_taken());
    chk("running", running, m_state == 1);
    chk("done", done, m_state == 2);
    chk("overflow", overflow, m_ovf);
    chk("instr_count", instr_count, m_cnt);
  end

  task automatic set_in(input bit h, input bit bi, input logic [1:0] bc, input logic [5:0] im,
                        input bit cf, input logic [2:0] fi, input bit st);
    halt = h; branch_instr = bi; branch_cond = bc; immediate = im;
    change_flag = cf; flag_in = fi; stall = st;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic plain();
    set_in(0, 0, 2'd0, 6'd0, 0, 3'd0, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0;
    plain();
    #2;
    chk("reset_pc", pc, 0);
    chk("reset_running", running, 0);
    chk("reset_count", instr_count, 0);
    #10 rst_n = 1'b1;
    tick();
    start = 1'b1;
    tick();
    chk("launch_running", running, 1);
    chk("launch_pc", pc, 0);

    // five plain instructions then HALT at pc 5
    for (int i = 0; i < 5; i++) tick();
    chk("t1_pc5", pc, 5);
    set_in(1, 0, 2'd0, 6'd0, 0, 3'd0, 0);
    tick();
    plain();
    chk("t1_done", done, 1);
    chk("t1_halt_pc", pc, 5);
    chk("t1_count", instr_count, 6);
    chk("t1_ovf", overflow, 0);

    // flag set at pc 2, BEQ to 4<<3 at pc 3
    start = 1'b0; tick();
    start = 1'b1; tick();
    chk("t2_rerun_pc", pc, 0);
    tick(); tick();
    set_in(0, 0, 2'd0, 6'd0, 1, 3'b001, 0);
    tick();
    set_in(0, 1, 2'd1, 6'd4, 0, 3'd0, 0);
    #1 chk("t2_taken", branch_taken, 1);
    tick();
    plain();
    chk("t2_target", pc, 32);
    chk("t2_flags", flags, 1);

    // restart while running, then flag write and BEQ in one cycle
    start = 1'b0; tick();
    start = 1'b1; tick();
    chk("t3_restart_pc", pc, 0);
    chk("t3_restart_flags", flags, 0);
    chk("t3_restart_count", instr_count, 0);
    set_in(0, 1, 2'd1, 6'd4, 1, 3'b001, 0);
    #1 chk("t3_not_taken", branch_taken, 0);
    tick();
    plain();
    chk("t3_pc", pc, 1);
    chk("t3_flags", flags, 1);

    // stall three cycles on a taken branch at pc 7
    for (int i = 0; i < 6; i++) tick();
    chk("t4_pc7", pc, 7);
    set_in(0, 1, 2'd0, 6'd2, 0, 3'd0, 1);
    for (int i = 0; i < 3; i++) begin
      #1 chk("t4_stall_taken", branch_taken, 0);
      tick();
      chk("t4_stall_pc", pc, 7);
      chk("t4_stall_count", instr_count, 7);
    end
    stall = 1'b0;
    #1 chk("t4_resume_taken", branch_taken, 1);
    tick();
    chk("t4_resume_pc", pc, 16);
    chk("t4_resume_count", instr_count, 8);

    // jump to 504 and fall off the top
    set_in(0, 1, 2'd0, 6'd63, 0, 3'd0, 0);
    tick();
    plain();
    chk("t5_pc504", pc, 504);
    begin
      int n = 0;
      while (!done && n < 20) begin tick(); n++; end
    end
    chk("t5_done", done, 1);
    chk("t5_ovf", overflow, 1);
    chk("t5_pc", pc, 511);
    chk("t5_count", instr_count, 17);
    start = 1'b0; tick();
    start = 1'b1; tick();
    chk("t5_rerun_running", running, 1);
    chk("t5_rerun_pc", pc, 0);
    chk("t5_rerun_ovf", overflow, 0);
    chk("t5_rerun_count", instr_count, 0);

    // async reset at pc 40 with start held high
    set_in(0, 0, 2'd0, 6'd0, 1, 3'b110, 0);
    tick();
    set_in(0, 1, 2'd0, 6'd5, 0, 3'd0, 0);
    tick();
    plain();
    chk("t6_pc40", pc, 40);
    chk("t6_flags", flags, 6);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_pc", pc, 0);
    chk("t6_rst_flags", flags, 0);
    chk("t6_rst_running", running, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("t6_no_launch", running, 0);
    chk("t6_idle_pc", pc, 0);
    start = 1'b0; tick();
    start = 1'b1; tick();
    chk("t6_relaunch", running, 1);
    tick();
    chk("t6_relaunch_pc", pc, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
